// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: N_CH phase-aligned one-cycle strobes derived from clk, realigned at every master wrap.
// Optional macro CLK_EN_SCHED_STAT_EN adds a saturating master-wrap counter output (master_cnt_o).
package clk_en_sched_pkg;
  function automatic int calc_bw(input int v);
    int r;
    r = 1;
    for (int b = 1; b < 31; b++) begin
      if (v >= (1 << b)) r = b + 1;
    end
    return r;
  endfunction
endpackage

module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 250,
  localparam int CH_W   = calc_bw(N_CH - 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic [N_CH-1:0]  en_o,
  output logic             sync_o,
  output logic             busy,
  output logic             cfg_err
`ifdef CLK_EN_SCHED_STAT_EN
  ,
  output logic [31:0]      master_cnt_o
`endif
);

  localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(N_CH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_STOPPING} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_sh  [N_CH];
  logic [DIV_W-1:0] r_ph_sh   [N_CH];
  logic [DIV_W-1:0] r_div_act [N_CH];
  logic [DIV_W-1:0] r_ph_act  [N_CH];
  logic [DIV_W-1:0] r_cnt     [N_CH];
  logic [N_CH-1:0]  r_en;
  logic             r_sync;
  logic             r_busy;
  logic             r_cfg_err;

  logic             w_active;
  logic             w_wrap;
  logic             w_cfg_bad;
  logic [DIV_W-1:0] w_last [N_CH];
  logic [N_CH-1:0]  w_hit;
  logic [N_CH-1:0]  w_pwrap;
  logic [N_CH-1:0]  w_wr;

  assign w_active = (r_state == S_RUN) || (r_state == S_STOPPING);
  assign w_wrap   = w_active && w_pwrap[0];

  // Out-of-range channels are rejected here, so the shadow write loop below never sees them.
  assign w_cfg_bad = ((cfg_div != '0) && (cfg_phase >= cfg_div)) ||
                     ({1'b0, cfg_ch} >= NCH_V) ||
                     ((cfg_ch == '0) && (cfg_div == '0));

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_last[i] = '0;
      if (r_div_act[i] != '0) w_last[i] = r_div_act[i] - DIV_W'(1);
      w_pwrap[i] = (r_div_act[i] != '0) && (r_cnt[i] == w_last[i]);
      w_hit[i]   = (r_div_act[i] != '0) && (r_cnt[i] == r_ph_act[i]);
      w_wr[i]    = cfg_we && !w_cfg_bad && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_en      <= '0;
      r_sync    <= 1'b0;
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]     <= '0;
        r_div_sh[i]  <= DIV_W'(DIV_RST);
        r_ph_sh[i]   <= '0;
        r_div_act[i] <= DIV_W'(DIV_RST);
        r_ph_act[i]  <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we && w_cfg_bad;
      r_en      <= w_active ? w_hit : '0;
      r_sync    <= w_wrap;
      for (int i = 0; i < N_CH; i++) begin
        if (w_wr[i]) begin
          r_div_sh[i] <= cfg_div;
          r_ph_sh[i]  <= cfg_phase;
        end
      end
      case (r_state)
        S_IDLE: begin
          for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
          if (start && !stop) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < N_CH; i++) begin
            r_cnt[i]     <= '0;
            r_div_act[i] <= r_div_sh[i];
            r_ph_act[i]  <= r_ph_sh[i];
          end
          r_state <= S_RUN;
        end
        default: begin
          // RUN and STOPPING share the counter advance; a master wrap realigns every channel.
          for (int i = 0; i < N_CH; i++) begin
            if (w_wrap || w_pwrap[i] || (r_div_act[i] == '0)) r_cnt[i] <= '0;
            else r_cnt[i] <= r_cnt[i] + DIV_W'(1);
          end
          if (r_state == S_RUN) begin
            if (w_wrap) begin
              for (int i = 0; i < N_CH; i++) begin
                r_div_act[i] <= r_div_sh[i];
                r_ph_act[i]  <= r_ph_sh[i];
              end
            end
            if (stop) r_state <= S_STOPPING;
          end else if (w_wrap) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign en_o    = r_en;
  assign sync_o  = r_sync;
  assign busy    = r_busy;
  assign cfg_err = r_cfg_err;

`ifdef CLK_EN_SCHED_STAT_EN
  logic [31:0] r_master_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_master_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_master_cnt <= '0;
    end else if (w_wrap && (r_master_cnt != 32'hFFFF_FFFF)) begin
      r_master_cnt <= r_master_cnt + 32'd1;
    end
  end

  assign master_cnt_o = r_master_cnt;
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched (N_CH=4 main instance, N_CH=5 instance for out-of-range channel writes).
`timescale 1ns/1ps
module tb_clk_en_sched;
  logic        clk = 1'b0;
  logic        rst_n, start, stop, cfg_we, cfg_we5;
  logic [2:0]  cfg_ch3;
  logic [15:0] cfg_div, cfg_phase;
  logic [3:0]  en_o;
  logic        sync_o, busy, cfg_err;
  logic [4:0]  en5;
  logic        sync5, busy5, err5;
`ifdef CLK_EN_SCHED_STAT_EN
  logic [31:0] master_cnt_o, master_cnt5;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] en_log [0:599];
  logic       sync_log [0:599];

  always #2 clk = ~clk;

  clk_en_sched #(.N_CH(4), .DIV_W(16), .DIV_RST(250)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch3[1:0]), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .en_o(en_o), .sync_o(sync_o), .busy(busy), .cfg_err(cfg_err)
`ifdef CLK_EN_SCHED_STAT_EN
    , .master_cnt_o(master_cnt_o)
`endif
  );

  clk_en_sched #(.N_CH(5), .DIV_W(16), .DIV_RST(250)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .stop(1'b0), .cfg_we(cfg_we5),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .en_o(en5), .sync_o(sync5), .busy(busy5), .cfg_err(err5)
`ifdef CLK_EN_SCHED_STAT_EN
    , .master_cnt_o(master_cnt5)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input int dv, input int ph);
    cfg_ch3 = ch; cfg_div = 16'(dv); cfg_phase = 16'(ph); cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_capture(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
      en_log[c] = en_o;
      sync_log[c] = sync_o;
    end
  endtask

  task automatic stop_to_idle();
    int k;
    stop = 1'b1;
    for (k = 0; k < 600 && busy; k++) tick();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL stop_timeout: busy=%b want 0", busy); else n_pass++;
    tick();
    n_checks++; if ({en_o, sync_o} !== 5'b0) $display("FAIL idle_quiet: en_o=%b sync_o=%b want 0", en_o, sync_o); else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; cfg_we = 0; cfg_we5 = 0; cfg_ch3 = 0; cfg_div = 0; cfg_phase = 0;
    tick(); tick();
    n_checks++; if ({en_o, sync_o, busy, cfg_err} !== 7'b0) $display("FAIL reset_outs: got %b want 0", {en_o, sync_o, busy, cfg_err}); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_default();
    int ne, ns;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else n_pass++;
    for (int c = 0; c < 260; c++) begin
      tick(); en_log[c] = en_o; sync_log[c] = sync_o;
    end
    n_checks++; if (en_log[0] !== 4'h0) $display("FAIL dflt_en_c0: got %h want 0", en_log[0]); else n_pass++;
    n_checks++; if (en_log[1] !== 4'hF) $display("FAIL dflt_en_c1: got %h want f", en_log[1]); else n_pass++;
    n_checks++; if (en_log[251] !== 4'hF) $display("FAIL dflt_en_c251: got %h want f", en_log[251]); else n_pass++;
    n_checks++; if (sync_log[250] !== 1'b1) $display("FAIL dflt_sync_c250: got %b want 1", sync_log[250]); else n_pass++;
    ne = 0; ns = 0;
    for (int c = 0; c < 260; c++) begin
      if (en_log[c] != 4'h0) ne++;
      if (sync_log[c]) ns++;
    end
    n_checks++; if (ne !== 2) $display("FAIL dflt_en_count: got %0d want 2", ne); else n_pass++;
    n_checks++; if (ns !== 1) $display("FAIL dflt_sync_count: got %0d want 1", ns); else n_pass++;
    stop_to_idle();
  endtask

  task automatic test_shadow_cfg();
    logic [3:0] ex;
    cfg_write(3'd0, 20, 0); cfg_write(3'd1, 5, 2); cfg_write(3'd2, 4, 3); cfg_write(3'd3, 0, 0);
    n_checks++; if (cfg_err !== 1'b0) $display("FAIL shadow_cfg_err: got %b want 0", cfg_err); else n_pass++;
    run_capture(41);
    for (int c = 0; c < 41; c++) begin
      ex = 4'h0;
      if (c >= 1) begin
        ex[0] = ((c - 1) % 20 == 0);
        ex[1] = (((c - 1) % 20) % 5 == 2);
        ex[2] = (((c - 1) % 20) % 4 == 3);
      end
      n_checks++; if (en_log[c] !== ex) $display("FAIL shadow_en c=%0d: got %b want %b", c, en_log[c], ex); else n_pass++;
    end
    n_checks++; if ({sync_log[19], sync_log[20], sync_log[40]} !== 3'b011) $display("FAIL shadow_sync: got %b want 011", {sync_log[19], sync_log[20], sync_log[40]}); else n_pass++;
    stop_to_idle();
  endtask

  task automatic test_stop_align();
    cfg_write(3'd0, 10, 0); cfg_write(3'd1, 5, 4);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL stopping_busy: got %b want 1", busy); else n_pass++;
    tick();
    n_checks++; if (en_o !== 4'b0010) $display("FAIL stopping_en_c5: got %b want 0010", en_o); else n_pass++;
    tick(); tick(); tick(); tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL stopping_busy_c9: got %b want 1", busy); else n_pass++;
    tick();
    n_checks++; if ({busy, sync_o, en_o} !== 6'b01_0010) $display("FAIL stop_final: busy,sync,en=%b want 010010", {busy, sync_o, en_o}); else n_pass++;
    tick();
    n_checks++; if ({busy, sync_o, en_o} !== 6'b0) $display("FAIL stop_after: busy,sync,en=%b want 0", {busy, sync_o, en_o}); else n_pass++;
    start = 1'b1; stop = 1'b1;
    tick(); tick(); tick();
    start = 1'b0; stop = 1'b0;
    n_checks++; if ({busy, en_o} !== 5'b0) $display("FAIL start_stop_idle: busy,en=%b want 0", {busy, en_o}); else n_pass++;
  endtask

  task automatic test_live_update();
    logic ex;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      tick(); en_log[c] = en_o; sync_log[c] = sync_o;
      if (c == 10) begin
        cfg_we = 1'b0;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL live_cfg_err: got %b want 0", cfg_err); else n_pass++;
      end
      if (c == 9) begin
        cfg_ch3 = 3'd1; cfg_div = 16'd2; cfg_phase = 16'd0; cfg_we = 1'b1;
      end
    end
    for (int c = 1; c <= 30; c++) begin
      ex = ((c - 1) / 10 < 2) ? (((c - 1) % 10) % 5 == 4) : (((c - 1) % 10) % 2 == 0);
      n_checks++; if (en_log[c][1] !== ex) $display("FAIL live_en1 c=%0d: got %b want %b", c, en_log[c][1], ex); else n_pass++;
    end
    stop_to_idle();
  endtask

  task automatic test_invalid();
    cfg_write(3'd1, 4, 4);
    n_checks++; if (cfg_err !== 1'b1) $display("FAIL inv_phase_err: got %b want 1", cfg_err); else n_pass++;
    tick();
    n_checks++; if (cfg_err !== 1'b0) $display("FAIL inv_err_width: got %b want 0", cfg_err); else n_pass++;
    cfg_write(3'd0, 0, 0);
    n_checks++; if (cfg_err !== 1'b1) $display("FAIL inv_ch0_div0_err: got %b want 1", cfg_err); else n_pass++;
    cfg_ch3 = 3'd5; cfg_div = 16'd7; cfg_phase = 16'd1; cfg_we5 = 1'b1;
    tick();
    cfg_we5 = 1'b0;
    n_checks++; if (err5 !== 1'b1) $display("FAIL inv_ch_range_err: got %b want 1", err5); else n_pass++;
    tick();
    n_checks++; if (err5 !== 1'b0) $display("FAIL inv_ch_range_width: got %b want 0", err5); else n_pass++;
    cfg_ch3 = 3'd4; cfg_we5 = 1'b1;
    tick();
    cfg_we5 = 1'b0;
    n_checks++; if (err5 !== 1'b0) $display("FAIL valid_ch4_err: got %b want 0", err5); else n_pass++;
    run_capture(12);
    for (int c = 1; c <= 10; c++) begin
      n_checks++; if (en_log[c][1] !== ((c - 1) % 2 == 0)) $display("FAIL inv_keep_ch1 c=%0d: got %b", c, en_log[c][1]); else n_pass++;
    end
    n_checks++; if ({en_log[1][0], sync_log[10], en_log[11][0]} !== 3'b111) $display("FAIL inv_keep_ch0: got %b want 111", {en_log[1][0], sync_log[10], en_log[11][0]}); else n_pass++;
    stop_to_idle();
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if ({en_o, sync_o, busy, cfg_err} !== 7'b0) $display("FAIL midrst_outs: got %b want 0", {en_o, sync_o, busy, cfg_err}); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if ({en_o, sync_o, busy} !== 6'b0) $display("FAIL midrst_after: got %b want 0", {en_o, sync_o, busy}); else n_pass++;
`ifdef CLK_EN_SCHED_STAT_EN
    n_checks++; if (master_cnt_o !== 32'd0) $display("FAIL stat_reset: got %0d want 0", master_cnt_o); else n_pass++;
`endif
    run_capture(252);
    n_checks++; if ({en_log[1], en_log[11], en_log[251]} !== 12'hF0F) $display("FAIL midrst_default: got %h want f0f", {en_log[1], en_log[11], en_log[251]}); else n_pass++;
    n_checks++; if (sync_log[250] !== 1'b1) $display("FAIL midrst_sync: got %b want 1", sync_log[250]); else n_pass++;
`ifdef CLK_EN_SCHED_STAT_EN
    n_checks++; if (master_cnt_o !== 32'd1) $display("FAIL stat_1: got %0d want 1", master_cnt_o); else n_pass++;
    for (int c = 0; c < 250; c++) tick();
    n_checks++; if (master_cnt_o !== 32'd2) $display("FAIL stat_2: got %0d want 2", master_cnt_o); else n_pass++;
    for (int c = 0; c < 250; c++) tick();
    n_checks++; if (master_cnt_o !== 32'd3) $display("FAIL stat_3: got %0d want 3", master_cnt_o); else n_pass++;
`endif
    stop_to_idle();
  endtask

  task automatic test_div1();
    cfg_write(3'd2, 1, 0);
    run_capture(5);
    for (int c = 1; c < 5; c++) begin
      n_checks++; if (en_log[c][2] !== 1'b1) $display("FAIL div1_en c=%0d: got %b want 1", c, en_log[c][2]); else n_pass++;
    end
    stop_to_idle();
  endtask

  initial begin
    test_reset();
    test_default();
    test_shadow_cfg();
    test_stop_align();
    test_live_update();
    test_invalid();
    test_reset_mid_run();
    test_div1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
